pingpong_frame_buf: RTL and testbench
=====================================

Name: pingpong_frame_buf

Overview:
- Parametrised, single-clock, double-buffered (ping-pong) image frame store for the digit-recognition datapath.
- Sits between the pixel capture/downscale stage and the CNN engine.
- Writer streams one IMG_W x IMG_H frame into one bank while the reader randomly accesses the previously completed frame in the other bank.
- Adds over the plain 784x8 buffer: generic width/geometry, automatic write addressing, bank ownership flags, backpressure, and frame handshakes.

Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 28, frame width in pixels
- IMG_H, 28, frame height in pixels
- ADDR_W, 10, read address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_valid  in  1  pixel beat valid
- wr_ready  out  1  buffer can accept a beat
- wr_sof  in  1  first pixel of a frame, qualified by an accepted beat
- wr_data  in  DATA_W  pixel value
- frame_valid  out  1  a complete frame is readable
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  pixel index within the frame (row*IMG_W+col)
- rd_data  out  DATA_W  read data
- rd_data_valid  out  1  rd_data is valid this cycle
- rd_oob  out  1  the returned read was out of range
- rd_done  in  1  reader releases the current frame (single-cycle pulse)
- frame_done  out  1  single-cycle pulse when a write frame completes

Behaviour:
- Definitions: DEPTH = IMG_W*IMG_H. Two banks (0/1). Per-bank full flag. Pointers: wr_bank, rd_bank, wr_cnt (ADDR_W bits).
- Reset state: full[1:0]=0, wr_bank=0, rd_bank=0, wr_cnt=0. Output reset values: rd_data=0, rd_data_valid=0, rd_oob=0, frame_done=0, wr_ready=1, frame_valid=0. RAM contents are not reset.
- wr_ready = !full[wr_bank] (combinational). A beat is accepted when wr_valid && wr_ready.
- Accepted beat address:
  - wr_sof=1: write to {wr_bank,0} and set wr_cnt=1. This resynchronises and discards any partial frame.
  - wr_sof=0: write to {wr_bank,wr_cnt} and increment wr_cnt.
- Frame completion: when the accepted beat's effective index is DEPTH-1, on the next edge set full[wr_bank]=1, toggle wr_bank, clear wr_cnt, and pulse frame_done for one cycle.
- A beat with wr_sof=1 that is also at index DEPTH-1 is not possible when DEPTH>1. For DEPTH=1, every beat completes a frame.
- frame_valid = full[rd_bank] (combinational).
- Read path: rd_en && frame_valid captures rd_addr. One cycle later rd_data_valid=1 and rd_data=mem[{rd_bank,rd_addr}].
  - If rd_addr >= DEPTH: rd_data=0 and rd_oob=1 with that valid.
  - rd_en while !frame_valid is ignored: no valid, data holds.
  - Back-to-back reads are allowed, one per cycle.
- Release: rd_done && frame_valid clears full[rd_bank] and toggles rd_bank on the next edge. rd_done while !frame_valid is ignored.
  - A read issued in the same cycle as rd_done still returns data from the old bank.
- Simultaneous frame completion and rd_done: both updates apply in the same edge. They target different banks, since the write bank is never full and the read bank always is.
- Both banks full: wr_ready=0 and the writer stalls. wr_ready rises the cycle after an accepted rd_done.
- Mid-operation reset: all flags and pointers return to reset values and any frame in flight is discarded. A read issued in the reset cycle produces no valid.
- Unconnected bits: none; widths are exact.

Decomposition:
- Shared package (pingpong_frame_buf_pkg):
  - DEPTH localparam function
  - clog2 helper
  - elaboration-time check that 2**ADDR_W >= DEPTH
- One sub-module, sdp_ram_1clk:
  - Generic single-clock simple dual-port RAM: one write port, one registered-address read port, 1-cycle read latency.
  - Depth 2**(ADDR_W+1), width DATA_W, inferable as block RAM.
  - Bank select is the address MSB.

Test Plan:
- Reset, then write 784 beats (data = index mod 256, wr_sof on the first beat) -> frame_done pulses once, frame_valid=1, wr_ready stays 1. Read addr 0, 27, 783 -> 0x00, 0x1B, 0x0F, each after 1 cycle.
- Write a second frame (data = 0xFF - index mod 256) without rd_done -> wr_ready=0 after it completes. The writer stalls with no data corruption. Read addr 5 still returns 0x05.
- Pulse rd_done -> next cycle reads addr 5 return 0xFA, and wr_ready=1 again.
- Read with rd_addr=800 -> rd_data=0, rd_oob=1, rd_data_valid=1. rd_en while frame_valid=0 -> no rd_data_valid.
- Write 300 beats, then wr_sof with a new 784-beat frame -> the frame completes after exactly 784 further beats and the partial data is never visible.
- Assert rst mid-frame and mid-read -> all outputs return to reset values on the next edge, frame_valid=0, wr_ready=1.

Source files
------------

// File: rtl/pingpong_frame_buf_pkg.sv
// Shared helpers for the ping-pong frame buffer: frame depth, ceil-log2 and
// the elaboration-time check that the read address can span a whole frame.
package pingpong_frame_buf_pkg;

    // Number of pixels in one frame.
    function automatic int calc_depth(input int img_w, input int img_h);
        return img_w * img_h;
    endfunction

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 32'sd0;
        v      = value - 32'sd1;
        while (v > 32'sd0) begin
            result = result + 32'sd1;
            v      = v >>> 1;
        end
        return result;
    endfunction

    // True when an addr_w-bit index can address every pixel of a frame.
    function automatic bit addr_w_fits(input int addr_w, input int depth);
        return (clog2(depth) <= addr_w);
    endfunction

endpackage

// File: rtl/pingpong_frame_buf_sdp_ram.sv
// Generic single-clock simple dual-port RAM: one write port and one read
// port with a one-cycle registered read, written so it maps onto block RAM.
module sdp_ram_1clk
    import pingpong_frame_buf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] rdata_r;

    // Write port: store one word per enabled cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port: registered read, result appears the cycle after re.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/pingpong_frame_buf.sv
// Double-buffered frame store: the writer fills one bank with auto-addressed
// pixel beats while the reader randomly accesses the completed frame in the
// other bank. Bank ownership is tracked by one full flag per bank.
module pingpong_frame_buf
    import pingpong_frame_buf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              wr_sof,
    input  logic [DATA_W-1:0] wr_data,
    output logic              frame_valid,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              rd_oob,
    input  logic              rd_done,
    output logic              frame_done
);

    localparam int                DEPTH     = calc_depth(IMG_W, IMG_H);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_IDX   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    if (!addr_w_fits(ADDR_W, DEPTH)) begin : g_addr_w_check
        $error("pingpong_frame_buf: ADDR_W too small for IMG_W*IMG_H");
    end

    logic [1:0]        full_r;
    logic [1:0]        full_set_s;
    logic [1:0]        full_clr_s;
    logic [1:0]        full_nxt_s;
    logic              wr_bank_r;
    logic              rd_bank_r;
    logic [ADDR_W-1:0] wr_cnt_r;
    logic [ADDR_W-1:0] wr_idx_s;
    logic              wr_accept_s;
    logic              wr_last_s;
    logic              ram_we_s;
    logic [ADDR_W:0]   ram_waddr_s;
    logic [ADDR_W:0]   ram_raddr_s;
    logic [DATA_W-1:0] ram_rdata_s;
    logic              rd_issue_s;
    logic              rd_release_s;
    logic              rd_oob_s;
    logic              rd_valid_r;
    logic              rd_oob_r;
    logic [DATA_W-1:0] rd_hold_r;
    logic [DATA_W-1:0] rd_fresh_s;
    logic              frame_done_r;

    // The writer owns wr_bank until it fills; the reader owns rd_bank while full.
    assign wr_ready    = ~full_r[wr_bank_r];
    assign frame_valid = full_r[rd_bank_r];

    // A start-of-frame beat always lands at index 0, discarding any partial frame.
    assign wr_accept_s = wr_valid & wr_ready;
    assign wr_idx_s    = wr_sof ? {ADDR_W{1'b0}} : wr_cnt_r;
    assign wr_last_s   = (wr_idx_s == LAST_IDX);

    // Writes are suppressed during reset so an in-flight beat never lands.
    assign ram_we_s    = wr_accept_s & ~rst;
    assign ram_waddr_s = {wr_bank_r, wr_idx_s};

    // Reads always target the current read bank, even in the release cycle.
    assign rd_issue_s   = rd_en & frame_valid;
    assign rd_release_s = rd_done & frame_valid;
    assign rd_oob_s     = ({1'b0, rd_addr} >= DEPTH_EXT);
    assign ram_raddr_s  = {rd_bank_r, rd_addr};

    // Completion and release may coincide; they always touch different banks.
    assign full_set_s = (wr_accept_s & wr_last_s) ? (2'b01 << wr_bank_r) : 2'b00;
    assign full_clr_s = rd_release_s ? (2'b01 << rd_bank_r) : 2'b00;
    assign full_nxt_s = (full_r | full_set_s) & ~full_clr_s;

    // Out-of-range reads return zero; between reads the last value is held.
    assign rd_fresh_s    = rd_oob_r ? {DATA_W{1'b0}} : ram_rdata_s;
    assign rd_data       = rd_valid_r ? rd_fresh_s : rd_hold_r;
    assign rd_data_valid = rd_valid_r;
    assign rd_oob        = rd_oob_r;
    assign frame_done    = frame_done_r;

    sdp_ram_1clk #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W + 1)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (wr_data),
        .re    (rd_issue_s),
        .raddr (ram_raddr_s),
        .rdata (ram_rdata_s)
    );

    // Bank flags, write/read pointers and registered read/frame status.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r       <= 2'b00;
            wr_bank_r    <= 1'b0;
            rd_bank_r    <= 1'b0;
            wr_cnt_r     <= {ADDR_W{1'b0}};
            frame_done_r <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_oob_r     <= 1'b0;
            rd_hold_r    <= {DATA_W{1'b0}};
        end else begin
            full_r       <= full_nxt_s;
            frame_done_r <= wr_accept_s & wr_last_s;
            if (wr_accept_s) begin
                if (wr_last_s) begin
                    wr_bank_r <= ~wr_bank_r;
                    wr_cnt_r  <= {ADDR_W{1'b0}};
                end else begin
                    wr_cnt_r  <= wr_idx_s + ONE_IDX;
                end
            end
            if (rd_release_s) begin
                rd_bank_r <= ~rd_bank_r;
            end
            rd_valid_r <= rd_issue_s;
            rd_oob_r   <= rd_issue_s & rd_oob_s;
            if (rd_valid_r) begin
                rd_hold_r <= rd_fresh_s;
            end
        end
    end

endmodule

// File: tb/tb_pingpong_frame_buf.sv
// Directed bench for pingpong_frame_buf: read vectors from a table plus
// hand-written sequences for backpressure, release, resync and reset.
module tb_pingpong_frame_buf;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_sof;
    logic [7:0] wr_data;
    logic       frame_valid;
    logic       rd_en;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_data_valid;
    logic       rd_oob;
    logic       rd_done;
    logic       frame_done;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] exp_data;
        logic       exp_oob;
    } rd_vec_t;

    rd_vec_t vecs [14];

    pingpong_frame_buf #(
        .DATA_W (8),
        .IMG_W  (28),
        .IMG_H  (28),
        .ADDR_W (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_sof        (wr_sof),
        .wr_data       (wr_data),
        .frame_valid   (frame_valid),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .rd_oob        (rd_oob),
        .rd_done       (rd_done),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // mode 0: data = index, mode 1: data = 0xFF - index, other: constant 0xAA
    task automatic write_beats(input int n, input int mode, input bit sof_first,
                               output int done_cnt, output int done_beat, output int stall_cnt);
        done_cnt  = 0;
        done_beat = 0;
        stall_cnt = 0;
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_sof   = sof_first && (i == 0);
            case (mode)
                0:       wr_data = 8'(i);
                1:       wr_data = 8'hFF - 8'(i);
                default: wr_data = 8'hAA;
            endcase
            if (!wr_ready) stall_cnt++;
            step();
            if (frame_done) begin
                done_cnt++;
                if (done_beat == 0) done_beat = i + 1;
            end
        end
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
        step();
        if (frame_done) done_cnt++;
    endtask

    task automatic run_reads(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rd_en   = 1'b1;
            rd_addr = vecs[i].addr;
            step();
            check($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(vecs[i].exp_data));
            check($sformatf("rd_valid[%0d]", i), 32'(rd_data_valid), 32'd1);
            check($sformatf("rd_oob[%0d]", i), 32'(rd_oob), 32'(vecs[i].exp_oob));
        end
        rd_en = 1'b0;
        step();
        check($sformatf("rd_valid_idle[%0d]", hi), 32'(rd_data_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_data"},     32'(rd_data), 32'd0);
        check({tag, "_rd_valid"},    32'(rd_data_valid), 32'd0);
        check({tag, "_rd_oob"},      32'(rd_oob), 32'd0);
        check({tag, "_frame_done"},  32'(frame_done), 32'd0);
        check({tag, "_wr_ready"},    32'(wr_ready), 32'd1);
        check({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    endtask

    initial begin
        int dc;
        int db;
        int sc;
        int bad;

        vecs[0]  = '{10'd0,    8'h00, 1'b0};
        vecs[1]  = '{10'd27,   8'h1B, 1'b0};
        vecs[2]  = '{10'd783,  8'h0F, 1'b0};
        vecs[3]  = '{10'd5,    8'h05, 1'b0};
        vecs[4]  = '{10'd0,    8'h00, 1'b0};
        vecs[5]  = '{10'd5,    8'hFA, 1'b0};
        vecs[6]  = '{10'd783,  8'hF0, 1'b0};
        vecs[7]  = '{10'd800,  8'h00, 1'b1};
        vecs[8]  = '{10'd1023, 8'h00, 1'b1};
        vecs[9]  = '{10'd5,    8'hFA, 1'b0};
        vecs[10] = '{10'd0,    8'hFF, 1'b0};
        vecs[11] = '{10'd299,  8'hD4, 1'b0};
        vecs[12] = '{10'd300,  8'hD3, 1'b0};
        vecs[13] = '{10'd10,   8'h0A, 1'b0};

        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
        wr_data  = 8'h00;
        rd_en    = 1'b0;
        rd_addr  = 10'd0;
        rd_done  = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Frame A into bank 0.
        write_beats(784, 0, 1'b1, dc, db, sc);
        check("frameA_done_cnt", 32'(dc), 32'd1);
        check("frameA_done_beat", 32'(db), 32'd784);
        check("frameA_stalls", 32'(sc), 32'd0);
        check("frameA_valid", 32'(frame_valid), 32'd1);
        check("frameA_wr_ready", 32'(wr_ready), 32'd1);
        run_reads(0, 2);

        // Frame B into bank 1 without releasing A: writer must stall afterwards.
        write_beats(784, 1, 1'b1, dc, db, sc);
        check("frameB_done_cnt", 32'(dc), 32'd1);
        check("frameB_stalls", 32'(sc), 32'd0);
        check("both_full_wr_ready", 32'(wr_ready), 32'd0);
        bad = 0;
        wr_valid = 1'b1;
        wr_sof   = 1'b1;
        wr_data  = 8'h77;
        for (int i = 0; i < 5; i++) begin
            step();
            if (wr_ready || frame_done) bad++;
        end
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
        check("stall_held", 32'(bad), 32'd0);
        run_reads(3, 4);

        // Release with a same-cycle read: read still sees the old bank.
        rd_done = 1'b1;
        rd_en   = 1'b1;
        rd_addr = 10'd5;
        step();
        rd_done = 1'b0;
        rd_en   = 1'b0;
        check("release_read_data", 32'(rd_data), 32'h05);
        check("release_read_valid", 32'(rd_data_valid), 32'd1);
        check("release_wr_ready", 32'(wr_ready), 32'd1);
        check("release_frame_valid", 32'(frame_valid), 32'd1);
        run_reads(5, 9);

        // Release B: no frame readable, reads and releases are ignored.
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        check("empty_frame_valid", 32'(frame_valid), 32'd0);
        check("empty_wr_ready", 32'(wr_ready), 32'd1);
        rd_en   = 1'b1;
        rd_addr = 10'd3;
        step();
        rd_en = 1'b0;
        check("ignored_read_valid", 32'(rd_data_valid), 32'd0);
        check("ignored_read_hold", 32'(rd_data), 32'hFA);
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        check("ignored_release_valid", 32'(frame_valid), 32'd0);

        // Partial frame, then resync with a fresh start-of-frame.
        write_beats(300, 2, 1'b1, dc, db, sc);
        check("partial_done_cnt", 32'(dc), 32'd0);
        write_beats(784, 1, 1'b1, dc, db, sc);
        check("resync_done_cnt", 32'(dc), 32'd1);
        check("resync_done_beat", 32'(db), 32'd784);
        check("resync_frame_valid", 32'(frame_valid), 32'd1);
        run_reads(10, 12);

        // Reset mid-frame with a read issued in the reset cycle.
        write_beats(100, 0, 1'b1, dc, db, sc);
        check("midframe_done_cnt", 32'(dc), 32'd0);
        rst      = 1'b1;
        rd_en    = 1'b1;
        rd_addr  = 10'd10;
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        step();
        check_reset_outputs("midrst");
        rst      = 1'b0;
        rd_en    = 1'b0;
        wr_valid = 1'b0;
        step();
        check("post_rst_valid", 32'(rd_data_valid), 32'd0);
        write_beats(784, 0, 1'b1, dc, db, sc);
        check("post_rst_done_cnt", 32'(dc), 32'd1);
        check("post_rst_frame_valid", 32'(frame_valid), 32'd1);
        run_reads(13, 13);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
